audio_stream_serializer: RTL and testbench

//  Parametrised parallel-to-serial audio output stage. Accepts DATA_W-bit samples over a valid/ready

---
 rtl/audio_stream_serializer.sv | 88 ++++++++
 tb/tb_audio_stream_serializer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/audio_stream_serializer.sv
// audio_stream_serializer: valid/ready sample input, gapless serial output with BIT_DIV clocks per bit.
module audio_stream_serializer #(
  parameter int DATA_W     = 16,
  parameter int BIT_DIV    = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      audio_enable,
  output logic                      audio_data,
  output logic                      word_done,
  output logic                      underrun,
  output logic [$clog2(DATA_W)-1:0] bit_count
);
  localparam int CW = $clog2(DATA_W);
  localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(BIT_DIV - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, sh_q, sh_d;
  logic hold_full_q, hold_full_d, ad_q, ad_d, done_q, done_d, urun_q, urun_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic xfer, run, step, last, load;
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction
  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w << 1 : w >> 1;
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      ad_q        <= IDLE_LEVEL;
      done_q      <= 1'b0;
      urun_q      <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      ad_q        <= ad_d;
      done_q      <= done_d;
      urun_q      <= urun_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else if (state_q == IDLE) state_d = hold_full_q ? SHIFT : IDLE;
    else if (step && last && !hold_full_q) state_d = IDLE;
  end
  // A reload at word end lands on the same edge as the last bit retires, so words abut.
  always_comb begin
    xfer        = in_valid && !hold_full_q;
    run         = enable && state_q == SHIFT;
    step        = run && div_q == LAST_DIV;
    last        = cnt_q == LAST_BIT;
    load        = enable && hold_full_q && (state_q == IDLE || (step && last));
    hold_d      = xfer ? in_data : hold_q;
    hold_full_d = xfer || (hold_full_q && !load);
    div_d       = (run && !step && !load) ? div_q + DW'(1) : '0;
    cnt_d       = (!run || load) ? '0 : !step ? cnt_q : last ? '0 : cnt_q + CW'(1);
    sh_d        = load ? shifted(hold_q) : (step && !last) ? shifted(sh_q) : run ? sh_q : '0;
    ad_d        = load ? first_bit(hold_q) : (step && !last) ? first_bit(sh_q) : (run && !step) ? ad_q : IDLE_LEVEL;
    done_d      = step && last;
    urun_d      = step && last && !hold_full_q;
  end
  assign in_ready     = !hold_full_q;
  assign audio_enable = enable;
  assign audio_data   = ad_q;
  assign word_done    = done_q;
  assign underrun     = urun_q;
  assign bit_count    = cnt_q;
endmodule

// File: tb/tb_audio_stream_serializer.sv
// tb_audio_stream_serializer: directed vectors for the default serializer and a BIT_DIV=4 LSB-first one.
module tb_audio_stream_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, vld, rdy, aen, ad, done, urun;
  logic [15:0] data;
  logic [3:0] cnt;
  logic en4, vld4, rdy4, aen4, ad4, done4, urun4;
  logic [15:0] data4;
  logic [3:0] cnt4;
  int checks = 0, errors = 0;
  audio_stream_serializer dut (
    .clock(clk), .reset(rst), .enable(en), .in_data(data), .in_valid(vld), .in_ready(rdy),
    .audio_enable(aen), .audio_data(ad), .word_done(done), .underrun(urun), .bit_count(cnt)
  );
  audio_stream_serializer #(.DATA_W(16), .BIT_DIV(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u4 (
    .clock(clk), .reset(rst), .enable(en4), .in_data(data4), .in_valid(vld4), .in_ready(rdy4),
    .audio_enable(aen4), .audio_data(ad4), .word_done(done4), .underrun(urun4), .bit_count(cnt4)
  );
  typedef struct {
    logic rst, en, vld;
    logic [15:0] data;
    logic rdy, ad, done, urun;
    logic [3:0] cnt;
  } vec_t;
  vec_t tv[21];
  logic [15:0] serial = 16'b1010_0101_1100_0011;
  logic [15:0] words[3];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit xf;
    int idx, j;
    rst = 1'b1; en = 1'b0; vld = 1'b0; data = '0;
    en4 = 1'b0; vld4 = 1'b0; data4 = '0;
    tv[0] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int k = 0; k < 16; k++)
      tv[3+k] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, serial[15-k], 1'b0, 1'b0, 4'(k)};
    tv[19] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
    tv[20] = '{1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 0; i < 21; i++) begin
      rst = tv[i].rst; en = tv[i].en; vld = tv[i].vld; data = tv[i].data;
      tick();
      chk($sformatf("v%0d_ready", i), rdy, tv[i].rdy);
      chk($sformatf("v%0d_data", i), ad, tv[i].ad);
      chk($sformatf("v%0d_done", i), done, tv[i].done);
      chk($sformatf("v%0d_underrun", i), urun, tv[i].urun);
      chk($sformatf("v%0d_count", i), cnt, tv[i].cnt);
    end
    chk("audio_enable_hi", aen, 1);
    // streamed words with in_valid held: 48 contiguous bits
    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h8001;
    idx = 0; vld = 1'b1; data = words[0];
    for (int c = 0; c < 50; c++) begin
      xf = vld && rdy;
      tick();
      if (xf) idx++;
      vld = idx < 3;
      data = idx < 3 ? words[idx] : 16'h0;
      if (c >= 1 && c <= 48) begin
        j = c - 1;
        chk($sformatf("stream_bit%0d", j), ad, words[j/16][15-(j%16)]);
        chk($sformatf("stream_done%0d", j), done, int'(j == 16 || j == 32));
        chk($sformatf("stream_urun%0d", j), urun, 0);
      end else if (c == 49) begin
        chk("stream_end_data", ad, 0);
        chk("stream_end_done", done, 1);
        chk("stream_end_urun", urun, 1);
      end
    end
    // BIT_DIV=4, LSB first, 16'h0003
    en4 = 1'b1; vld4 = 1'b1; data4 = 16'h0003;
    tick();
    vld4 = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c <= 64) begin
        chk($sformatf("div4_bit_c%0d", c), ad4, int'(c <= 8));
        chk($sformatf("div4_cnt_c%0d", c), cnt4, (c - 1) / 4);
        chk($sformatf("div4_done_c%0d", c), done4, 0);
      end else begin
        chk("div4_end_done", done4, 1);
        chk("div4_end_urun", urun4, 1);
        chk("div4_end_data", ad4, 0);
        chk("div4_end_cnt", cnt4, 0);
      end
    end
    // enable dropped at bit_count 7 of F0F0 with a second word held
    vld = 1'b1; data = 16'hF0F0;
    tick();
    vld = 1'b0;
    tick();
    chk("en_first_bit", ad, 1);
    vld = 1'b1; data = 16'h8001;
    tick();
    vld = 1'b0;
    repeat (6) tick();
    chk("en_cnt7", cnt, 7);
    chk("en_bit7", ad, 0);
    chk("en_held_ready", rdy, 0);
    en = 1'b0;
    #1;
    chk("audio_enable_lo", aen, 0);
    tick();
    chk("en_flush_data", ad, 0);
    chk("en_flush_cnt", cnt, 0);
    chk("en_flush_done", done, 0);
    chk("en_flush_urun", urun, 0);
    chk("en_hold_kept", rdy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("en_off_done%0d", i), done, 0);
      chk($sformatf("en_off_data%0d", i), ad, 0);
    end
    en = 1'b1;
    tick();
    chk("en_resume_bit0", ad, 1);
    chk("en_resume_cnt", cnt, 0);
    chk("en_resume_ready", rdy, 1);
    tick();
    chk("en_resume_bit1", ad, 0);
    chk("en_resume_cnt1", cnt, 1);
    // reset mid-word with the holding register full, in_valid high during reset
    vld = 1'b1; data = 16'hFFFF;
    tick();
    chk("rst_pre_full", rdy, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready", rdy, 1);
    chk("rst_data", ad, 0);
    chk("rst_done", done, 0);
    chk("rst_urun", urun, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0; vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_data%0d", i), ad, 0);
      chk($sformatf("post_rst_ready%0d", i), rdy, 1);
      chk($sformatf("post_rst_cnt%0d", i), cnt, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
